// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between ALU results and memory
// loads. Round-robin priority per cycle. The memory side may lock the port
// for a burst. A lock that keeps the ALU waiting too long is broken.
// The winning write is registered one cycle later as wb_en/wb_dest/wb_data.
module regfile_wb_arbiter #(
   parameter int DATA_W      = 16,
   parameter int MAX_LOCK    = 8,
   parameter bit ZERO_REG_WE = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              alu_valid,
   input  logic [3:0]        alu_dest,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_ready,
   input  logic              mem_valid,
   input  logic [3:0]        mem_dest,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_lock,
   output logic              mem_ready,
   input  logic              flush,
   output logic              wb_en,
   output logic [3:0]        wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              lock_abort
);

   typedef enum logic [1:0] {
      PRI_MEM  = 2'd0,
      PRI_ALU  = 2'd1,
      LOCK_MEM = 2'd2
   } state_t;

   localparam int CNT_W = $clog2(MAX_LOCK + 1);
   localparam logic [CNT_W-1:0] LAST_BLOCK = CNT_W'(MAX_LOCK - 1);

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    starve_cnt, starve_cnt_nxt;
   logic                grant_alu, grant_mem, lock_break;
   logic                xfer, write_ok;
   logic [3:0]          sel_dest;
   logic [DATA_W-1:0]   sel_data;

   // Grant decision, next state and starvation bookkeeping.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      grant_alu      = 1'b0;
      grant_mem      = 1'b0;
      lock_break     = 1'b0;
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;

      if (flush) begin
         state_nxt      = PRI_MEM;
         starve_cnt_nxt = '0;
      end else begin
         unique case (state)
            PRI_MEM: begin
               grant_mem = mem_valid;
               grant_alu = alu_valid && !mem_valid;
            end
            PRI_ALU: begin
               grant_alu = alu_valid;
               grant_mem = mem_valid && !alu_valid;
            end
            LOCK_MEM: begin
               // The ALU has waited long enough: the lock is dropped and this cycle is idle.
               if (alu_valid && (starve_cnt == LAST_BLOCK)) lock_break = 1'b1;
               else                                        grant_mem  = mem_valid;
            end
            default: ;
         endcase

         if (lock_break)     state_nxt = PRI_ALU;
         else if (grant_mem) state_nxt = mem_lock ? LOCK_MEM : PRI_ALU;
         else if (grant_alu) state_nxt = PRI_MEM;

         if (state_nxt != LOCK_MEM)                  starve_cnt_nxt = '0;
         else if (state == LOCK_MEM && alu_valid)    starve_cnt_nxt = starve_cnt + CNT_W'(1);
      end
   end

   // Winning request, and whether its destination may actually be written.
   always_comb begin
      xfer     = grant_alu || grant_mem;
      sel_dest = grant_alu ? alu_dest : mem_dest;
      sel_data = grant_alu ? alu_data : mem_data;
      write_ok = ZERO_REG_WE || (sel_dest != 4'd0);
   end

   assign alu_ready = grant_alu;
   assign mem_ready = grant_mem;

   // Arbiter state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= PRI_MEM;
         starve_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Writeback register: one-cycle-late write strobe; dest/data hold when idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_en      <= 1'b0;
         wb_dest    <= '0;
         wb_data    <= '0;
         lock_abort <= 1'b0;
      end else begin
         wb_en      <= xfer && write_ok;
         lock_abort <= lock_break;
         if (xfer) begin
            wb_dest <= sel_dest;
            wb_data <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// Two instances share the stimulus. Instance 0 has R0 writes enabled.
// Instance 1 suppresses R0 writes. A behavioural model predicts the
// ready outputs and the registered writeback outputs every cycle.
module tb_regfile_wb_arbiter;

   localparam int DW = 16;
   localparam int ML = 8;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          alu_valid, mem_valid, mem_lock, flush;
   logic [3:0]    alu_dest, mem_dest;
   logic [DW-1:0] alu_data, mem_data;

   logic [1:0]    alu_ready, mem_ready, wb_en, lock_abort;
   logic [3:0]    wb_dest [2];
   logic [DW-1:0] wb_data [2];

   int n_checks = 0;
   int n_errors = 0;

   // Model state: who is favoured, whether mem holds the port, blocked ALU cycles.
   bit            m_pref_alu, m_locked;
   int            m_blocked;
   bit            e_en [2];
   bit            e_abort;
   logic [3:0]    e_dest;
   logic [DW-1:0] e_data;

   regfile_wb_arbiter #(.DATA_W(DW), .MAX_LOCK(ML), .ZERO_REG_WE(1'b1)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready[0]),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_lock(mem_lock),
      .mem_ready(mem_ready[0]), .flush(flush),
      .wb_en(wb_en[0]), .wb_dest(wb_dest[0]), .wb_data(wb_data[0]), .lock_abort(lock_abort[0])
   );

   regfile_wb_arbiter #(.DATA_W(DW), .MAX_LOCK(ML), .ZERO_REG_WE(1'b0)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready[1]),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_lock(mem_lock),
      .mem_ready(mem_ready[1]), .flush(flush),
      .wb_en(wb_en[1]), .wb_dest(wb_dest[1]), .wb_data(wb_data[1]), .lock_abort(lock_abort[1])
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pref_alu = 1'b0;
      m_locked   = 1'b0;
      m_blocked  = 0;
      e_en[0]    = 1'b0;
      e_en[1]    = 1'b0;
      e_abort    = 1'b0;
      e_dest     = '0;
      e_data     = '0;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
      mem_valid = 1'b0; mem_dest = '0; mem_data = '0; mem_lock = 1'b0;
      flush     = 1'b0;
   endtask

   // One clock cycle: check readies mid-cycle, update model, check registered outputs after the edge.
   task automatic cycle(output bit ga, output bit gm);
      bit brk;
      @(negedge clk);
      #1;
      ga = 1'b0; gm = 1'b0; brk = 1'b0;
      if (!flush) begin
         if (m_locked) begin
            if (alu_valid && (m_blocked + 1 == ML)) brk = 1'b1;
            else                                   gm  = mem_valid;
         end else if (m_pref_alu) begin
            ga = alu_valid;
            gm = mem_valid && !alu_valid;
         end else begin
            gm = mem_valid;
            ga = alu_valid && !mem_valid;
         end
      end
      for (int k = 0; k < 2; k++) begin
         check("alu_ready", alu_ready[k], ga);
         check("mem_ready", mem_ready[k], gm);
      end

      e_abort = brk;
      if (ga || gm) begin
         e_dest  = ga ? alu_dest : mem_dest;
         e_data  = ga ? alu_data : mem_data;
         e_en[0] = 1'b1;
         e_en[1] = (e_dest != 4'd0);
      end else begin
         e_en[0] = 1'b0;
         e_en[1] = 1'b0;
      end
      if (flush) begin
         m_pref_alu = 1'b0; m_locked = 1'b0; m_blocked = 0;
      end else if (brk) begin
         m_pref_alu = 1'b1; m_locked = 1'b0; m_blocked = 0;
      end else begin
         if (m_locked && alu_valid) m_blocked++;
         if (gm) begin m_pref_alu = 1'b1; m_locked = mem_lock; end
         if (ga) m_pref_alu = 1'b0;
         if (!m_locked) m_blocked = 0;
      end

      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check("wb_en",      wb_en[k],      e_en[k]);
         check("wb_dest",    wb_dest[k],    e_dest);
         check("wb_data",    wb_data[k],    e_data);
         check("lock_abort", lock_abort[k], e_abort);
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      idle_inputs();
      model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
         check("rst_wb_en",     wb_en[k],      1'b0);
         check("rst_wb_dest",   wb_dest[k],    4'd0);
         check("rst_wb_data",   wb_data[k],    16'd0);
         check("rst_abort",     lock_abort[k], 1'b0);
         check("rst_alu_ready", alu_ready[k],  1'b0);
         check("rst_mem_ready", mem_ready[k],  1'b0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit ga, gm;
      int cnt;
      logic [3:0] exp_rr [4];

      reset_n = 1'b1;
      idle_inputs();
      #2;
      apply_reset();

      // Round-robin with both sources always requesting: mem, alu, mem, alu.
      exp_rr[0] = 4'd5; exp_rr[1] = 4'd3; exp_rr[2] = 4'd5; exp_rr[3] = 4'd3;
      alu_valid = 1'b1; alu_dest = 4'd3; alu_data = 16'h1111;
      mem_valid = 1'b1; mem_dest = 4'd5; mem_data = 16'h2222;
      for (int i = 0; i < 4; i++) begin
         cycle(ga, gm);
         check("rr_dest", wb_dest[0], exp_rr[i]);
      end
      idle_inputs();

      // Single ALU request.
      alu_valid = 1'b1; alu_dest = 4'd7; alu_data = 16'hBEEF;
      cycle(ga, gm);
      check("alu_only_dest", wb_dest[0], 4'd7);
      check("alu_only_data", wb_data[0], 16'hBEEF);
      idle_inputs();

      // Three locked mem beats while the ALU waits; ALU wins right after.
      alu_valid = 1'b1; alu_dest = 4'd2; alu_data = 16'hA1A1;
      mem_valid = 1'b1; mem_dest = 4'd9;
      for (int i = 0; i < 3; i++) begin
         mem_data = 16'h9000 + 16'(i);
         mem_lock = (i < 2);
         cycle(ga, gm);
      end
      mem_valid = 1'b0; mem_lock = 1'b0;
      cycle(ga, gm);
      check("after_lock_dest", wb_dest[0], 4'd2);
      idle_inputs();

      // Starvation: lock taken, mem goes idle, ALU keeps asking.
      mem_valid = 1'b1; mem_lock = 1'b1; mem_dest = 4'd4; mem_data = 16'h4444;
      cycle(ga, gm);
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_dest = 4'd6; alu_data = 16'h6666;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(ga, gm);
         cnt++;
         if (lock_abort[0]) break;
      end
      check("starve_cycles", cnt, ML);
      check("starve_alu_wins", alu_ready[0], 1'b1);
      cycle(ga, gm);
      idle_inputs();

      // Flush with both requesting: no grant, no write next cycle.
      alu_valid = 1'b1; alu_dest = 4'd1; alu_data = 16'h0101;
      mem_valid = 1'b1; mem_dest = 4'd8; mem_data = 16'h0808;
      flush = 1'b1;
      cycle(ga, gm);
      check("flush_wb_en", wb_en[0], 1'b0);
      idle_inputs();

      // ALU write to R0: accepted by both, written only by instance 0.
      alu_valid = 1'b1; alu_dest = 4'd0; alu_data = 16'h55AA;
      cycle(ga, gm);
      check("r0_en_we1", wb_en[0], 1'b1);
      check("r0_en_we0", wb_en[1], 1'b0);
      check("r0_data_we0", wb_data[1], 16'h55AA);
      idle_inputs();

      // Reset in the middle of a lock.
      mem_valid = 1'b1; mem_lock = 1'b1; mem_dest = 4'd11; mem_data = 16'hBBBB;
      alu_valid = 1'b1; alu_dest = 4'd12; alu_data = 16'hCCCC;
      cycle(ga, gm);
      cycle(ga, gm);
      apply_reset();
      alu_valid = 1'b1; alu_dest = 4'd12; alu_data = 16'hCCCC;
      mem_valid = 1'b1; mem_dest = 4'd11; mem_data = 16'hBBBB; mem_lock = 1'b0;
      cycle(ga, gm);
      check("post_reset_mem_first", wb_dest[0], 4'd11);
      idle_inputs();

      // Randomized traffic; requests hold until accepted.
      for (int i = 0; i < 3000; i++) begin
         flush = ($urandom_range(15) == 0);
         cycle(ga, gm);
         if (ga || !alu_valid) begin
            alu_valid = ($urandom_range(3) != 0);
            alu_dest  = 4'($urandom_range(15));
            alu_data  = 16'($urandom);
         end
         if (gm || !mem_valid) begin
            mem_valid = ($urandom_range(1) != 0);
            mem_dest  = 4'($urandom_range(15));
            mem_data  = 16'($urandom);
            mem_lock  = ($urandom_range(3) != 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
